// File: rtl/count_down_pkg.sv
// count_down_pkg
// Shared definitions for the loadable down-counter/timer.
//   state_t     : controller states (IDLE, RUN, DONE)
//   COUNT_WIDTH : default counter width, shared with the loadable up-counter
package count_down_pkg;

    localparam int COUNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : count_down_pkg

// File: rtl/count_down.sv
// count_down
// Loadable down-counter/timer. Loads a start value, counts toward zero while
// enabled and pulses tc for one cycle at terminal count. In periodic mode
// (auto_reload=1) the last loaded value is reloaded at terminal count, so the
// block acts as a tick generator with a period of the reload value in enabled
// cycles.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   din         in   start value, sampled when load=1
//   load        in   load din into count and reload register (any state)
//   en          in   count enable, decrement while running
//   auto_reload in   1 = periodic, 0 = one-shot; sampled at the count==1 step
//   count       out  current counter value
//   tc          out  terminal-count pulse, one cycle wide
//   busy        out  high while in RUN
//   state_o     out  current controller state, for observation
//
// Handshake: there is no valid/ready pair. load and en are level qualifiers
// sampled at every rising edge, priority rst > load > count step; all
// outputs are registers or decoded from the registered state.
module count_down
    import count_down_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output state_t           state_o
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;

    // Next-state and datapath. tc defaults low so it can only ever be a
    // single-cycle pulse unless a terminal step repeats every cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = din;
            reload_d = din;
            // A zero load has nothing to count, so stay idle and never pulse.
            state_d  = (din != ZERO) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                // Periodic: jump straight to the reload value,
                                // count never shows zero.
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = DONE;
                            end
                        end else if (count_q != ZERO) begin
                            // Zero is unreachable in RUN; the guard keeps the
                            // counter from ever wrapping to all-ones.
                            count_d = count_q - ONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    // Parked until the next load.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign busy    = (state_q == RUN);
    assign state_o = state_q;

endmodule : count_down
